// File: rtl/rtc_pkg.sv
// ============================================================================
// rtc_pkg : field indices, timer state type and BCD calendar helpers
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package rtc_pkg;

  localparam logic [3:0] FLD_SEC   = 4'd0;
  localparam logic [3:0] FLD_MIN   = 4'd1;
  localparam logic [3:0] FLD_HOUR  = 4'd2;
  localparam logic [3:0] FLD_DAY   = 4'd3;
  localparam logic [3:0] FLD_MONTH = 4'd4;
  localparam logic [3:0] FLD_YEAR  = 4'd5;
  localparam logic [3:0] FLD_TSEC  = 4'd6;
  localparam logic [3:0] FLD_TMIN  = 4'd7;
  localparam logic [3:0] FLD_THOUR = 4'd8;

  typedef enum logic [0:0] {
    T_IDLE = 1'b0,
    T_RUN  = 1'b1
  } timer_state_t;

  // (10*t + u) mod 4 == (2*t + u) mod 4, so only the low two bits matter.
  function automatic logic [7:0] days_in_month(input logic [7:0] month_bcd,
                                               input logic [7:0] year_bcd);
    logic [4:0] s;
    s = {year_bcd[7:4], 1'b0} + {1'b0, year_bcd[3:0]};
    case (month_bcd)
      8'h02:                      days_in_month = (s[1:0] == 2'b00) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: days_in_month = 8'h30;
      default:                    days_in_month = 8'h31;
    endcase
  endfunction

  function automatic logic bcd_valid(input logic [7:0] b);
    bcd_valid = (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rtc_digit_bank_bcd2_counter.sv
// ============================================================================
// bcd2_counter : two-digit BCD register with runtime min/max, inc/dec, load
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module bcd2_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rst_val,
  input  logic [7:0] min_val,
  input  logic [7:0] max_val,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       carry,
  output logic       borrow
);

  logic [7:0] up_val;
  logic [7:0] dn_val;

  // ">=" on carry lets a stale value above max (e.g. day after a month write) wrap.
  assign carry  = inc & (value >= max_val);
  assign borrow = dec & (value <= min_val);

  always_comb begin
    up_val = (value[3:0] == 4'd9) ? {value[7:4] + 4'd1, 4'd0} : {value[7:4], value[3:0] + 4'd1};
    dn_val = (value[3:0] == 4'd0) ? {value[7:4] - 4'd1, 4'd9} : {value[7:4], value[3:0] - 4'd1};
  end

  always_ff @(posedge clk) begin
    if (reset)
      value <= rst_val;
    else if (load)
      value <= load_val;
    else if (inc)
      value <= carry ? min_val : up_val;
    else if (dec)
      value <= borrow ? max_val : dn_val;
  end

endmodule

`default_nettype wire

// File: rtl/rtc_digit_bank.sv
// ============================================================================
// rtc_digit_bank : 12 h clock, calendar and countdown timer as BCD digits
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module rtc_digit_bank
  import rtc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       wr_en,
  input  logic [3:0] wr_sel,
  input  logic [7:0] wr_data,
  input  logic       wr_pm,
  input  logic       timer_start,
  input  logic       timer_stop,
  output logic [3:0] d0,  output logic [3:0] d1,  output logic [3:0] d2,
  output logic [3:0] d3,  output logic [3:0] d4,  output logic [3:0] d5,
  output logic [3:0] d6,  output logic [3:0] d7,  output logic [3:0] d8,
  output logic [3:0] d9,  output logic [3:0] d10, output logic [3:0] d11,
  output logic [3:0] d12, output logic [3:0] d13, output logic [3:0] d14,
  output logic [3:0] d15, output logic [3:0] d16, output logic [3:0] d17,
  output logic       am_pm,
  output logic       timer_running,
  output logic       timer_done
);

  logic [7:0] sec, min, hour, day, month, year, tsec, tmin, thour;
  logic       sec_c, min_c, day_c, month_c, tsec_b, tmin_b;
  logic [11:0] spare_unused;
  logic [7:0] dim;
  logic       tick_eff, wr_ok, day_inc, hour_11;
  logic       ld_sec, ld_min, ld_hour, ld_day, ld_month, ld_year;
  logic       ld_tsec, ld_tmin, ld_thour;
  logic       t_zero, t_one, t_tick, t_dec, done_d;
  timer_state_t state_q, state_d;

  // A write in the same cycle swallows the tick for every counter.
  assign tick_eff = tick_1hz & ~wr_en;
  assign wr_ok    = wr_en & bcd_valid(wr_data);
  assign dim      = days_in_month(month, year);

  assign ld_sec   = wr_ok && (wr_sel == FLD_SEC)   && (wr_data <= 8'h59);
  assign ld_min   = wr_ok && (wr_sel == FLD_MIN)   && (wr_data <= 8'h59);
  assign ld_hour  = wr_ok && (wr_sel == FLD_HOUR)  && (wr_data >= 8'h01) && (wr_data <= 8'h12);
  assign ld_day   = wr_ok && (wr_sel == FLD_DAY)   && (wr_data >= 8'h01) && (wr_data <= dim);
  assign ld_month = wr_ok && (wr_sel == FLD_MONTH) && (wr_data >= 8'h01) && (wr_data <= 8'h12);
  assign ld_year  = wr_ok && (wr_sel == FLD_YEAR)  && (wr_data <= 8'h99);
  assign ld_tsec  = wr_ok && (wr_sel == FLD_TSEC)  && (wr_data <= 8'h59);
  assign ld_tmin  = wr_ok && (wr_sel == FLD_TMIN)  && (wr_data <= 8'h59);
  assign ld_thour = wr_ok && (wr_sel == FLD_THOUR) && (wr_data <= 8'h23);

  assign hour_11 = (hour == 8'h11);
  assign day_inc = min_c & hour_11 & am_pm;

  bcd2_counter u_sec (.clk(clk), .reset(reset), .rst_val(8'h00), .min_val(8'h00), .max_val(8'h59),
    .inc(tick_eff), .dec(1'b0), .load(ld_sec), .load_val(wr_data), .value(sec),
    .carry(sec_c), .borrow(spare_unused[0]));
  bcd2_counter u_min (.clk(clk), .reset(reset), .rst_val(8'h00), .min_val(8'h00), .max_val(8'h59),
    .inc(sec_c), .dec(1'b0), .load(ld_min), .load_val(wr_data), .value(min),
    .carry(min_c), .borrow(spare_unused[1]));
  bcd2_counter u_hour (.clk(clk), .reset(reset), .rst_val(8'h12), .min_val(8'h01), .max_val(8'h12),
    .inc(min_c), .dec(1'b0), .load(ld_hour), .load_val(wr_data), .value(hour),
    .carry(spare_unused[2]), .borrow(spare_unused[3]));
  bcd2_counter u_day (.clk(clk), .reset(reset), .rst_val(8'h01), .min_val(8'h01), .max_val(dim),
    .inc(day_inc), .dec(1'b0), .load(ld_day), .load_val(wr_data), .value(day),
    .carry(day_c), .borrow(spare_unused[4]));
  bcd2_counter u_month (.clk(clk), .reset(reset), .rst_val(8'h01), .min_val(8'h01), .max_val(8'h12),
    .inc(day_c), .dec(1'b0), .load(ld_month), .load_val(wr_data), .value(month),
    .carry(month_c), .borrow(spare_unused[5]));
  bcd2_counter u_year (.clk(clk), .reset(reset), .rst_val(8'h00), .min_val(8'h00), .max_val(8'h99),
    .inc(month_c), .dec(1'b0), .load(ld_year), .load_val(wr_data), .value(year),
    .carry(spare_unused[6]), .borrow(spare_unused[7]));

  always_ff @(posedge clk) begin
    if (reset)
      am_pm <= 1'b0;
    else if (ld_hour)
      am_pm <= wr_pm;
    else if (min_c && hour_11)
      am_pm <= ~am_pm;
  end

  // Decrement is suppressed at zero so a zeroed-while-running timer stays 00:00:00.
  assign t_zero = ({thour, tmin, tsec} == 24'h000000);
  assign t_one  = ({thour, tmin, tsec} == 24'h000001);
  assign t_tick = (state_q == T_RUN) && tick_eff && !timer_stop;
  assign t_dec  = t_tick && !t_zero;

  bcd2_counter u_tsec (.clk(clk), .reset(reset), .rst_val(8'h00), .min_val(8'h00), .max_val(8'h59),
    .inc(1'b0), .dec(t_dec), .load(ld_tsec), .load_val(wr_data), .value(tsec),
    .carry(spare_unused[8]), .borrow(tsec_b));
  bcd2_counter u_tmin (.clk(clk), .reset(reset), .rst_val(8'h00), .min_val(8'h00), .max_val(8'h59),
    .inc(1'b0), .dec(tsec_b), .load(ld_tmin), .load_val(wr_data), .value(tmin),
    .carry(spare_unused[9]), .borrow(tmin_b));
  bcd2_counter u_thour (.clk(clk), .reset(reset), .rst_val(8'h00), .min_val(8'h00), .max_val(8'h23),
    .inc(1'b0), .dec(tmin_b), .load(ld_thour), .load_val(wr_data), .value(thour),
    .carry(spare_unused[10]), .borrow(spare_unused[11]));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= T_IDLE;
      timer_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_done <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      T_IDLE: if (timer_start && !timer_stop && !t_zero) state_d = T_RUN;
      T_RUN: begin
        if (timer_stop) begin
          state_d = T_IDLE;
        end else if (t_tick && (t_one || t_zero)) begin
          state_d = T_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = T_IDLE;
    endcase
  end

  assign timer_running = (state_q == T_RUN);

  assign {d1, d0}   = sec;    assign {d3, d2}   = min;   assign {d5, d4}   = hour;
  assign {d7, d6}   = day;    assign {d9, d8}   = month; assign {d11, d10} = year;
  assign {d13, d12} = tsec;   assign {d15, d14} = tmin;  assign {d17, d16} = thour;

endmodule

`default_nettype wire

// File: doc/rtc_digit_bank.md
# rtc_digit_bank

Time, date and countdown-timer register bank that produces the eighteen BCD digits and the AM/PM flag consumed by the VGA text display stage. Advances on an external 1 Hz enable pulse and accepts field writes from the front-panel/keypad controller. All outputs are registered, so the display stage sees stable digits for the whole frame between ticks.

## Interface
- No parameters; all ranges are fixed by the clock/calendar definition.
- clk  in  1  system clock (same domain as the display stage input)
- reset  in  1  synchronous, active-high
- tick_1hz  in  1  one-cycle enable, once per second
- wr_en  in  1  field write strobe
- wr_sel  in  4  field index: 0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year, 6 tsec, 7 tmin, 8 thour; 9–15 ignored
- wr_data  in  8  two BCD digits, [7:4] tens, [3:0] units
- wr_pm  in  1  AM/PM value loaded with a hour write (wr_sel=2)
- timer_start  in  1  pulse: start countdown
- timer_stop  in  1  pulse: pause countdown
- d0..d17  out  4 each  BCD digits: d0–d5 sec u/t, min u/t, hour u/t; d6–d11 day u/t, month u/t, year u/t; d12–d17 timer sec u/t, min u/t, hour u/t
- am_pm  out  1  0 = AM, 1 = PM
- timer_running  out  1  countdown FSM in RUN
- timer_done  out  1  one-cycle pulse when countdown reaches zero

## Operation
- Reset: time 12:00:00, am_pm=0, date 01/01/00, timer 00:00:00, FSM IDLE, timer_done=0.
- Clock, 12 h: sec 00–59, min 00–59, hour 01–12. 11:59:59→12:00:00 toggles am_pm. 12:59:59→01:00:00 does not toggle am_pm.
- Date advances when 11:59:59 PM→12:00:00 AM. Day range is 01..days(month). Feb has 29 days when year mod 4 = 0 (year 00 counts as a leap year). Month 12→01 increments year. Year 99→00 wraps.
- Writes:
  - Accepted only if both nibbles are ≤9 and the value is in the field's range.
  - Ranges: sec/min 00–59, hour 01–12, day 01–31, month 01–12, year 00–99, tsec/tmin 00–59, thour 00–23.
  - Out-of-range or non-BCD writes are dropped and leave no state change.
  - A day write larger than days(current month) is dropped.
  - Month/year writes do not re-clamp day. On the next rollover check, any day > days(month) is treated as end of month.
- Simultaneous wr_en and tick_1hz: the write is applied and the tick is discarded for the clock, the date and the timer.
- Timer FSM states:
  - IDLE: timer_start with timer ≠ 0 goes to RUN. timer_start with timer = 0 is ignored.
  - RUN: each tick decrements hh:mm:ss with borrow. timer_stop goes to IDLE.
  - When a tick takes 00:00:01→00:00:00: go to IDLE and assert timer_done.
- timer_start and timer_stop in the same cycle: stop wins.
- Timer writes are accepted in both states. Writing all timer fields to zero while in RUN leaves the FSM in RUN. The next tick then returns it to IDLE with timer_done=1, and the value stays 00:00:00.

## Timing
- Digits and am_pm update on the clk edge that samples tick_1hz/wr_en. They are visible one cycle after the strobe.
- timer_done is registered and asserted on the same edge as the zero value. It is high for exactly one cycle.
- timer_running reflects the FSM state register, with no combinational path from inputs.
- Full carry chain (sec→min→hour→am_pm→day→month→year) settles in that single cycle, with no ripple over multiple ticks.
- reset applied mid-count restores the reset values at the next edge and overrides all other inputs.

## Structure
- Package rtc_pkg holds:
  - field index constants FLD_SEC..FLD_THOUR
  - the timer state enum (T_IDLE, T_RUN)
  - function days_in_month(month_bcd, year_bcd)
  - function bcd_valid(byte)
- Sub-module bcd2_counter: two-digit BCD register with runtime min/max, inc/dec enables, load port, and carry/borrow out. It is instantiated nine times: date uses dynamic max, and the timer uses decrement.

## Test plan
- Reset → d5..d0 = 1,2,0,0,0,0; d11..d6 = 0,0,0,1,0,1; am_pm=0; timer all 0; timer_running=0.
- Write hour 0x11 with wr_pm=1, min 0x59, sec 0x59; then one tick → 12:00:00, am_pm=0, date 02/01/00.
- Write date 28/02/04, time 11:59:59 PM; tick → 29/02/04. Repeat with year 03 → 01/03/03.
- Write tsec=0x02, then timer_start, then 2 ticks → timer 00:00:00, timer_done high one cycle on the 2nd tick edge, timer_running=0.
- Write min=0x60, or sec=0x1A → value unchanged. Write and tick in the same cycle → written value held and the other fields do not advance.
- timer_start and timer_stop in the same cycle from IDLE with a nonzero timer → stays IDLE. Reset asserted while in RUN → timer 00:00:00, IDLE.
